// File: rtl/bsg_negedge_credit_rx.sv
// Credit-based receiver for a falling-edge launched word stream.
// Buffers words in a small FIFO and returns one credit per dequeue.
//
// Ports:
//   clk_i       : clock, all state updates on rising edge
//   reset_n_i   : asynchronous active-low reset
//   v_i         : word valid from transmitter (launched on falling edge)
//   data_i      : word from transmitter (launched on falling edge)
//   credit_o    : one-cycle pulse returning a buffer credit
//   v_o         : buffer head valid
//   data_o      : buffer head word
//   yumi_i      : consumer accepts head (legal only while v_o=1)
//   overflow_o  : sticky flag, word arrived with no credit available

module bsg_negedge_credit_rx #(
    parameter int width_p = 16,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               credit_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               overflow_o
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [cnt_w-1:0] full_c = cnt_w'(els_p);

    logic [width_p-1:0] mem_q [els_p];

    logic [ptr_w-1:0] wptr_q, wptr_d;
    logic [ptr_w-1:0] rptr_q, rptr_d;
    logic [cnt_w-1:0] cnt_q,  cnt_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic enq, deq;

    // A yumi with an empty buffer is ignored; a full buffer still
    // accepts a word when the head leaves in the same cycle.
    always_comb begin
        deq = yumi_i & (cnt_q != '0);
        enq = v_i & ((cnt_q != full_c) | deq);
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        credit_d   = deq;
        overflow_d = overflow_q | (v_i & ~enq);
        // Power-of-two depth: pointers wrap by natural overflow.
        if (enq) begin
            wptr_d = wptr_q + ptr_w'(1);
        end
        if (deq) begin
            rptr_d = rptr_q + ptr_w'(1);
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + cnt_w'(1);
            2'b01:   cnt_d = cnt_q - cnt_w'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; head is don't-care when empty.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign v_o        = (cnt_q != '0);
    assign data_o     = mem_q[rptr_q];
    assign credit_o   = credit_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bsg_negedge_credit_rx.sv
// Self-checking bench for bsg_negedge_credit_rx.
// Queue-based reference model, directed plus random stimulus.

module tb_bsg_negedge_credit_rx;

    localparam int W   = 16;
    localparam int ELS = 2;

    logic         clk = 1'b0;
    logic         reset_n_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         credit_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic         overflow_o;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic         m_credit;
    int           credit_cnt;

    bsg_negedge_credit_rx #(.width_p(W), .els_p(ELS)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .v_i        (v_i),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_credit = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".v_o"}, 32'(v_o), 32'(mq.size() != 0));
        if (mq.size() != 0)
            chk({tag, ".data_o"}, 32'(data_o), 32'(mq[0]));
        chk({tag, ".credit_o"}, 32'(credit_o), 32'(m_credit));
        chk({tag, ".overflow_o"}, 32'(overflow_o), 32'(m_ovf));
        chk({tag, ".cnt"}, 32'(dut.cnt_q), 32'(mq.size()));
    endtask

    // Drive on the falling edge, update the model for the next rising
    // edge, then check outputs just after that edge.
    task automatic cycle(input string tag, input logic v,
                         input logic [W-1:0] d, input logic y);
        logic deq, enq;
        @(negedge clk);
        v_i = v;
        data_i = d;
        yumi_i = y;
        deq = y && (mq.size() != 0);
        enq = v && ((mq.size() < ELS) || deq);
        if (v && !enq) m_ovf = 1'b1;
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back(d);
        m_credit = deq;
        @(posedge clk);
        #1;
        if (credit_o) credit_cnt++;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n_i = 1'b0;
        v_i = 1'b0;
        yumi_i = 1'b0;
        data_i = '0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    initial begin
        reset_n_i = 1'b0;
        v_i = 1'b0;
        yumi_i = 1'b0;
        data_i = '0;
        credit_cnt = 0;
        model_clear();
        #1;
        check_outputs("reset_async");
        do_reset();
        #1;
        check_outputs("reset_state");

        // Basic transfer with yumi held high.
        credit_cnt = 0;
        cycle("basic0", 1'b1, 16'hA5A5, 1'b1);
        chk("basic.data_const", 32'(data_o), 32'h0000A5A5);
        cycle("basic1", 1'b0, 16'h0000, 1'b1);
        chk("basic.credit_const", 32'(credit_o), 32'h1);
        cycle("basic2", 1'b0, 16'h0000, 1'b1);
        cycle("basic3", 1'b0, 16'h0000, 1'b0);
        chk("basic.credit_total", 32'(credit_cnt), 32'd1);

        // Fill, then overflow.
        credit_cnt = 0;
        cycle("fill0", 1'b1, 16'h0001, 1'b0);
        cycle("fill1", 1'b1, 16'h0002, 1'b0);
        chk("fill.data_const", 32'(data_o), 32'h1);
        chk("fill.no_credit", 32'(credit_cnt), 32'd0);
        cycle("ovf0", 1'b1, 16'h0003, 1'b0);
        chk("ovf.flag_const", 32'(overflow_o), 32'h1);
        cycle("drain0", 1'b0, 16'h0000, 1'b1);
        chk("drain.second", 32'(data_o), 32'h2);
        cycle("drain1", 1'b0, 16'h0000, 1'b1);
        cycle("drain2", 1'b0, 16'h0000, 1'b1);
        chk("ovf.sticky", 32'(overflow_o), 32'h1);

        // Reset mid-operation: one word buffered, credit pending.
        cycle("mid0", 1'b1, 16'h1111, 1'b0);
        cycle("mid1", 1'b1, 16'h2222, 1'b0);
        cycle("mid2", 1'b0, 16'h0000, 1'b1);
        #2;
        reset_n_i = 1'b0;
        model_clear();
        #1;
        chk("midrst.v_o", 32'(v_o), 32'h0);
        chk("midrst.credit_o", 32'(credit_o), 32'h0);
        chk("midrst.overflow_o", 32'(overflow_o), 32'h0);
        @(negedge clk);
        v_i = 1'b0;
        yumi_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        credit_cnt = 0;
        cycle("post0", 1'b0, 16'h0000, 1'b1);
        cycle("post1", 1'b0, 16'h0000, 1'b0);
        chk("midrst.no_credit", 32'(credit_cnt), 32'd0);

        // Full with simultaneous enqueue and dequeue.
        cycle("sim0", 1'b1, 16'h0001, 1'b0);
        cycle("sim1", 1'b1, 16'h0002, 1'b0);
        cycle("sim2", 1'b1, 16'h0003, 1'b1);
        chk("sim.ovf", 32'(overflow_o), 32'h0);
        chk("sim.cnt", 32'(dut.cnt_q), 32'd2);
        chk("sim.head", 32'(data_o), 32'h2);
        cycle("sim3", 1'b0, 16'h0000, 1'b1);
        chk("sim.next", 32'(data_o), 32'h3);
        cycle("sim4", 1'b0, 16'h0000, 1'b1);

        // Streaming 100 words.
        do_reset();
        credit_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle("stream", 1'b1, W'(i + 16'h0100), 1'b1);
            chk("stream.cnt_le1", 32'(dut.cnt_q <= 1), 32'h1);
        end
        cycle("stream_drain", 1'b0, 16'h0000, 1'b1);
        cycle("stream_tail", 1'b0, 16'h0000, 1'b0);
        chk("stream.credits", 32'(credit_cnt), 32'd100);

        // Yumi while empty is ignored.
        cycle("yumi_empty", 1'b0, 16'h0000, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 99) < 60), W'($urandom),
                  ($urandom_range(0, 99) < 50));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
